// File: rtl/whack_a_mole_pkg.sv
// Shared types and default constants for the whack-a-mole game blocks.
package whack_a_mole_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPick
    } state_e;

    localparam int unsigned NumHolesDefault = 18;
    localparam int unsigned ClkPerMsDefault = 50000;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), steps only while advance is high.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= SEED;
        end else if (advance) begin
            value_q <= {1'b0, value_q[15:1]} ^ (value_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/mole_spawner.sv
// Raises up to NUM_MOLES moles on random holes, ages them in ms and clears on whack/timeout.
// Define MOLE_ESCAPE_EN to build the escaped-pulse reporting for timed-out moles.
module mole_spawner
    import whack_a_mole_pkg::*;
#(
    parameter int unsigned NUM_HOLES  = NumHolesDefault,
    parameter int unsigned NUM_MOLES  = 3,
    parameter int unsigned MOLE_UP_MS = 1000,
    parameter int unsigned CLK_PER_MS = ClkPerMsDefault,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           spawn,
    input  logic [NUM_HOLES-1:0]           whack_mask,
    output logic [NUM_HOLES-1:0]           mole_positions,
    output logic                           spawned,
    output logic                           escaped,
    output logic [$clog2(NUM_MOLES+1)-1:0] active_count
);

    localparam int unsigned HoleW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
    localparam int unsigned SlotW = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
    localparam int unsigned CdW   = $clog2(MOLE_UP_MS + 1);
    localparam int unsigned PsW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned CntW  = $clog2(NUM_MOLES + 1);
    localparam int unsigned AttW  = $clog2(2 * NUM_HOLES + 1);

    state_e                 state_q, state_d;
    logic [PsW-1:0]         ps_q;
    logic                   tick;
    logic [AttW-1:0]        att_q;
    logic [15:0]            lfsr;
    logic [HoleW-1:0]       cand;
    logic                   in_pick;

    logic [NUM_MOLES-1:0]   valid_q, valid_d;
    logic [HoleW-1:0]       hole_q [NUM_MOLES];
    logic [HoleW-1:0]       hole_d [NUM_MOLES];
    logic [CdW-1:0]         cd_q [NUM_MOLES];
    logic [CdW-1:0]         cd_d [NUM_MOLES];

    logic [NUM_HOLES-1:0]   occ, pos_d;
    logic                   free_found, load, full_after;
    logic [SlotW-1:0]       free_idx;
    logic [NUM_MOLES-1:0]   load_vec;
    logic [CntW-1:0]        cnt_d;
`ifdef MOLE_ESCAPE_EN
    logic [CntW-1:0]        n_to, pend_q, pend_d;
    logic [CntW:0]          total;
    logic                   esc_d;
`endif

    assign tick    = enable && (ps_q == PsW'(CLK_PER_MS - 1));
    assign in_pick = (state_q == StPick) && enable;
    assign cand    = HoleW'(32'(lfsr) % NUM_HOLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (!enable || tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PsW'(1);
        end
    end

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (in_pick),
        .value   (lfsr)
    );

    // Occupancy and free-slot search use only current state, so a slot freed by a
    // whack this cycle is not visible to the picker until the next cycle.
    always_comb begin
        occ        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            if (valid_q[i]) begin
                occ[hole_q[i]] = 1'b1;
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = SlotW'(i);
            end
        end
        load     = in_pick && free_found && !occ[cand];
        load_vec = '0;
        if (load) begin
            load_vec[free_idx] = 1'b1;
        end
        full_after = &(valid_q | load_vec);
    end

    always_comb begin
        valid_d = valid_q;
        hole_d  = hole_q;
        cd_d    = cd_q;
`ifdef MOLE_ESCAPE_EN
        n_to    = '0;
`endif
        for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            if (valid_q[i]) begin
                // Whack takes priority over a same-cycle timeout.
                if (whack_mask[hole_q[i]]) begin
                    valid_d[i] = 1'b0;
                end else if (tick) begin
                    if (cd_q[i] <= CdW'(1)) begin
                        valid_d[i] = 1'b0;
`ifdef MOLE_ESCAPE_EN
                        n_to = n_to + CntW'(1);
`endif
                    end else begin
                        cd_d[i] = cd_q[i] - CdW'(1);
                    end
                end
            end else if (load_vec[i]) begin
                valid_d[i] = 1'b1;
                hole_d[i]  = cand;
                cd_d[i]    = CdW'(MOLE_UP_MS);
            end
        end
        if (!enable) begin
            valid_d = '0;
`ifdef MOLE_ESCAPE_EN
            n_to    = '0;
`endif
        end
    end

    always_comb begin
        pos_d = '0;
        cnt_d = '0;
        for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            if (valid_d[i]) begin
                pos_d[hole_d[i]] = 1'b1;
            end
            cnt_d = cnt_d + CntW'(valid_d[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StArmed;
            StArmed: if (spawn) state_d = StPick;
            StPick:  if (full_after || att_q == AttW'(2 * NUM_HOLES - 1)) state_d = StArmed;
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            att_q          <= '0;
            valid_q        <= '0;
            mole_positions <= '0;
            active_count   <= '0;
            spawned        <= 1'b0;
            for (int unsigned i = 0; i < NUM_MOLES; i++) begin
                hole_q[i] <= '0;
                cd_q[i]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            att_q          <= in_pick ? att_q + AttW'(1) : '0;
            valid_q        <= valid_d;
            hole_q         <= hole_d;
            cd_q           <= cd_d;
            mole_positions <= pos_d;
            active_count   <= cnt_d;
            spawned        <= load;
        end
    end

`ifdef MOLE_ESCAPE_EN
    // Simultaneous timeouts are queued and reported one pulse per cycle.
    always_comb begin
        total  = {1'b0, pend_q} + {1'b0, n_to};
        esc_d  = (total != '0);
        pend_d = esc_d ? CntW'(total - {{CntW{1'b0}}, 1'b1}) : '0;
        if (!enable) begin
            esc_d  = 1'b0;
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            escaped <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            escaped <= esc_d;
        end
    end
`else
    assign escaped = 1'b0;
`endif

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner (18 holes, 3 moles, 2 ms life, 10 clk/ms).
module tb_mole_spawner;
    import whack_a_mole_pkg::*;

`ifdef MOLE_ESCAPE_EN
    localparam bit EscEn = 1'b1;
`else
    localparam bit EscEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        spawn = 1'b0;
    logic [17:0] whack_mask = '0;
    logic [17:0] mole_positions;
    logic        spawned;
    logic        escaped;
    logic [1:0]  active_count;

    int n_vec = 0;
    int n_err = 0;

    mole_spawner #(
        .NUM_HOLES  (18),
        .NUM_MOLES  (3),
        .MOLE_UP_MS (2),
        .CLK_PER_MS (10),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .spawn          (spawn),
        .whack_mask     (whack_mask),
        .mole_positions (mole_positions),
        .spawned        (spawned),
        .escaped        (escaped),
        .active_count   (active_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (mole_positions !== 18'h0) begin n_err++;
            $display("FAIL rst_pos got %h want 0", mole_positions); end
        n_vec++; if ({spawned, escaped, active_count} !== 4'b0) begin n_err++;
            $display("FAIL rst_outs got %b want 0000", {spawned, escaped, active_count}); end
        rst_n = 1'b1;
        step();
        n_vec++; if (dut.state_q !== StIdle) begin n_err++;
            $display("FAIL rst_state got %0d want IDLE", dut.state_q); end
        n_vec++; if (mole_positions !== 18'h0 || active_count !== 2'd0) begin n_err++;
            $display("FAIL rst_idle got pos=%h cnt=%0d want 0/0", mole_positions, active_count); end
    endtask

    // Seed ACE1 gives candidates 13, 8, 4.
    task automatic test_spawn();
        logic [17:0] exp_pos [3];
        exp_pos[0] = 18'h02000; exp_pos[1] = 18'h02100; exp_pos[2] = 18'h02110;
        enable = 1'b1;
        step();
        n_vec++; if (dut.state_q !== StArmed) begin n_err++;
            $display("FAIL arm_state got %0d want ARMED", dut.state_q); end
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        n_vec++; if (dut.state_q !== StPick) begin n_err++;
            $display("FAIL pick_state got %0d want PICK", dut.state_q); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (mole_positions !== exp_pos[k] || spawned !== 1'b1) begin n_err++;
                $display("FAIL spawn%0d got pos=%h sp=%b want pos=%h sp=1", k, mole_positions,
                         spawned, exp_pos[k]); end
        end
        n_vec++; if (active_count !== 2'd3 || dut.state_q !== StArmed) begin n_err++;
            $display("FAIL spawn_full got cnt=%0d st=%0d want 3/ARMED", active_count,
                     dut.state_q); end
        step();
        n_vec++; if (spawned !== 1'b0) begin n_err++;
            $display("FAIL spawn_done got sp=%b want 0", spawned); end
    endtask

    // Moles loaded at edges 3..5 expire together on the tick at edge 20.
    task automatic test_escape();
        int esc_seen = 0;
        for (int k = 7; k <= 19; k++) begin
            step();
            if (escaped) esc_seen++;
        end
        n_vec++; if (mole_positions !== 18'h02110 || esc_seen != 0) begin n_err++;
            $display("FAIL pre_timeout got pos=%h esc=%0d want 02110/0", mole_positions,
                     esc_seen); end
        step();
        n_vec++; if (mole_positions !== 18'h0 || active_count !== 2'd0) begin n_err++;
            $display("FAIL timeout_clr got pos=%h cnt=%0d want 0/0", mole_positions,
                     active_count); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (escaped !== EscEn) begin n_err++;
                $display("FAIL escape%0d got %b want %b", k, escaped, EscEn); end
            step();
        end
        n_vec++; if (escaped !== 1'b0) begin n_err++;
            $display("FAIL escape_end got %b want 0", escaped); end
    endtask

    // Holes 2, 10, 5; whack 10 early, whack 2 on the same tick that 2 and 5 time out.
    task automatic test_whack();
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        step(); step(); step();
        n_vec++; if (mole_positions !== 18'h00424 || active_count !== 2'd3) begin n_err++;
            $display("FAIL r2_spawn got pos=%h cnt=%0d want 00424/3", mole_positions,
                     active_count); end
        step(); step();
        whack_mask = ~18'h00424;
        step();
        whack_mask = '0;
        n_vec++; if (mole_positions !== 18'h00424 || active_count !== 2'd3) begin n_err++;
            $display("FAIL whack_empty got pos=%h cnt=%0d want 00424/3", mole_positions,
                     active_count); end
        whack_mask = 18'h00400;
        step();
        whack_mask = '0;
        n_vec++; if (mole_positions !== 18'h00024 || active_count !== 2'd2 || escaped !== 1'b0)
            begin n_err++;
            $display("FAIL whack_hit got pos=%h cnt=%0d esc=%b want 00024/2/0", mole_positions,
                     active_count, escaped); end
        repeat (8) step();
        whack_mask = 18'h00004;
        step();
        whack_mask = '0;
        n_vec++; if (mole_positions !== 18'h0 || escaped !== EscEn) begin n_err++;
            $display("FAIL whack_vs_timeout got pos=%h esc=%b want 0/%b", mole_positions,
                     escaped, EscEn); end
        step();
        n_vec++; if (escaped !== 1'b0) begin n_err++;
            $display("FAIL whack_wins got esc=%b want 0", escaped); end
    endtask

    // Holes 15, 5, 0; then drop enable.
    task automatic test_enable_drop();
        int bad = 0;
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        step(); step(); step();
        n_vec++; if (mole_positions !== 18'h08021 || active_count !== 2'd3) begin n_err++;
            $display("FAIL r3_spawn got pos=%h cnt=%0d want 08021/3", mole_positions,
                     active_count); end
        enable = 1'b0;
        step();
        n_vec++; if (mole_positions !== 18'h0 || active_count !== 2'd0 || escaped !== 1'b0)
            begin n_err++;
            $display("FAIL drop_clr got pos=%h cnt=%0d esc=%b want 0/0/0", mole_positions,
                     active_count, escaped); end
        n_vec++; if (dut.state_q !== StIdle) begin n_err++;
            $display("FAIL drop_state got %0d want IDLE", dut.state_q); end
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        n_vec++; if (dut.state_q !== StIdle || spawned !== 1'b0) begin n_err++;
            $display("FAIL idle_spawn got st=%0d sp=%b want IDLE/0", dut.state_q, spawned); end
        for (int k = 0; k < 15; k++) begin
            step();
            if (escaped !== 1'b0 || mole_positions !== 18'h0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++;
            $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
    endtask

    // LFSR must resume where it stopped: holes 0, 9, 2.
    task automatic test_lfsr_resume();
        logic [17:0] exp_pos [3];
        exp_pos[0] = 18'h00001; exp_pos[1] = 18'h00201; exp_pos[2] = 18'h00205;
        enable = 1'b1;
        step();
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (mole_positions !== exp_pos[k]) begin n_err++;
                $display("FAIL resume%0d got %h want %h", k, mole_positions, exp_pos[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_escape();
        test_whack();
        test_enable_drop();
        test_lfsr_resume();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
